// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared definitions for the forwarding mux pipeline:
//   - fwd_state_t   : skid-buffer occupancy state (EMPTY, BUSY, FULL)
//   - FWD_CNT_W     : width of the forwarded-operand counter
//   - FWD_DEF_WIDTH : default data width per source
//   - FWD_DEF_NSRC  : default number of forwarding sources
//   - fwd_sat_inc() : saturating increment for the counter
// -----------------------------------------------------------------------------
package fwd_pkg;

   localparam int FWD_CNT_W     = 32;
   localparam int FWD_DEF_WIDTH = 64;
   localparam int FWD_DEF_NSRC  = 4;

   // EMPTY: nothing buffered; BUSY: main holds an operand; FULL: main + skid hold one each
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } fwd_state_t;

   // Counter sticks at all-ones instead of wrapping back to zero
   function automatic logic [FWD_CNT_W-1:0] fwd_sat_inc(input logic [FWD_CNT_W-1:0] v);
      return (&v) ? v : v + FWD_CNT_W'(1);
   endfunction

endpackage

// File: rtl/fwd_mux_pipe_if.sv
// -----------------------------------------------------------------------------
// fwd_mux_pipe_if
// Bundle of the forwarding pipeline's upstream and downstream signals.
//   src_data  : NSRC packed source words, source k at [k*WIDTH +: WIDTH]
//   src_sel   : source select, taken on the input handshake
//   in_valid  : upstream offers src_data/src_sel
//   in_ready  : pipeline can accept
//   flush     : synchronous discard of everything buffered
//   out_valid : out_data/out_src hold an operand
//   out_ready : downstream consumes the operand
//   out_data  : selected operand
//   out_src   : effective select that produced out_data
// Modports: master = the side driving operands in and consuming them,
//           slave  = the pipeline itself.
// -----------------------------------------------------------------------------
interface fwd_mux_pipe_if
   import fwd_pkg::*;
#(
   parameter int WIDTH = FWD_DEF_WIDTH,
   parameter int NSRC  = FWD_DEF_NSRC
) ();

   localparam int SELW = $clog2(NSRC);

   logic [NSRC*WIDTH-1:0] src_data;
   logic [SELW-1:0]       src_sel;
   logic                  in_valid;
   logic                  in_ready;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH-1:0]      out_data;
   logic [SELW-1:0]       out_src;

   modport master (
      output src_data, src_sel, in_valid, flush, out_ready,
      input  in_ready, out_valid, out_data, out_src
   );

   modport slave (
      input  src_data, src_sel, in_valid, flush, out_ready,
      output in_ready, out_valid, out_data, out_src
   );

endinterface

// File: rtl/fwd_sel_n.sv
// -----------------------------------------------------------------------------
// fwd_sel_n
// Combinational NSRC:1 operand select.
//   src_data : packed sources, source k at [k*WIDTH +: WIDTH]
//   src_sel  : requested source
//   sel_data : chosen word
//   sel_src  : effective select (out-of-range requests fall back to 0)
// -----------------------------------------------------------------------------
module fwd_sel_n #(
   parameter int WIDTH = 64,
   parameter int NSRC  = 4
) (
   input  logic [NSRC*WIDTH-1:0]    src_data,
   input  logic [$clog2(NSRC)-1:0]  src_sel,
   output logic [WIDTH-1:0]         sel_data,
   output logic [$clog2(NSRC)-1:0]  sel_src
);

   localparam int SELW = $clog2(NSRC);
   // One extra bit so a power-of-two NSRC is representable
   localparam logic [SELW:0] SEL_LIMIT = (SELW+1)'(NSRC);

   logic [WIDTH-1:0] words [NSRC];
   logic [NSRC-1:0]  hit;
   logic             in_range;
   logic [SELW-1:0]  eff_sel;

   assign in_range = ({1'b0, src_sel} < SEL_LIMIT);
   assign eff_sel  = in_range ? src_sel : '0;
   assign sel_src  = eff_sel;

   // One-hot decode keeps the mux free of out-of-range array indexing
   // when NSRC is not a power of two.
   generate
      for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
         assign words[gi] = src_data[gi*WIDTH +: WIDTH];
         assign hit[gi]   = (eff_sel == SELW'(gi));
      end
   endgenerate

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NSRC; k++) begin
         sel_data = sel_data | (words[k] & {WIDTH{hit[k]}});
      end
   end

endmodule

// File: rtl/fwd_mux_pipe.sv
// -----------------------------------------------------------------------------
// fwd_mux_pipe
// Operand forwarding mux followed by a 2-entry skid buffer (main + skid
// register). Strict FIFO order, 1-cycle latency when empty, 1 operand/cycle
// sustained while out_ready stays high. in_ready and out_valid come straight
// from flops.
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high
//   bus       : fwd_mux_pipe_if.slave (operand in/out handshakes, flush)
//   fwd_count : count of accepted operands with non-zero effective select,
//               saturating; exists only when FWD_MUX_PIPE_STATS_EN is defined
// Build option: FWD_MUX_PIPE_STATS_EN compiles in fwd_count.
// NSRC legal range is 2..16.
// -----------------------------------------------------------------------------
module fwd_mux_pipe
   import fwd_pkg::*;
#(
   parameter int WIDTH = FWD_DEF_WIDTH,
   parameter int NSRC  = FWD_DEF_NSRC
) (
   input  logic                 clk,
   input  logic                 reset,
   fwd_mux_pipe_if.slave        bus
`ifdef FWD_MUX_PIPE_STATS_EN
   ,
   output logic [FWD_CNT_W-1:0] fwd_count
`endif
);

   localparam int SELW = $clog2(NSRC);

   fwd_state_t       state_reg;
   logic             in_ready_reg;
   logic             out_valid_reg;
   logic [WIDTH-1:0] main_data_reg;
   logic [SELW-1:0]  main_src_reg;
   logic [WIDTH-1:0] skid_data_reg;
   logic [SELW-1:0]  skid_src_reg;

   logic [WIDTH-1:0] sel_data;
   logic [SELW-1:0]  sel_src;
   logic             in_hs;
   logic             out_hs;

   fwd_sel_n #(
      .WIDTH (WIDTH),
      .NSRC  (NSRC)
   ) u_sel (
      .src_data (bus.src_data),
      .src_sel  (bus.src_sel),
      .sel_data (sel_data),
      .sel_src  (sel_src)
   );

   assign in_hs  = bus.in_valid && in_ready_reg;
   assign out_hs = out_valid_reg && bus.out_ready;

   assign bus.in_ready  = in_ready_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_data  = main_data_reg;
   assign bus.out_src   = main_src_reg;

   // in_ready_reg tracks (next state != FULL) and out_valid_reg tracks
   // (next state != EMPTY), so both are pure flops and agree with state_reg.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= EMPTY;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         main_data_reg <= '0;
         main_src_reg  <= '0;
         skid_data_reg <= '0;
         skid_src_reg  <= '0;
      end else if (bus.flush) begin
         // Buffered words stay in the registers but are no longer visible;
         // a same-cycle input handshake is ignored.
         state_reg     <= EMPTY;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (in_hs) begin
                  main_data_reg <= sel_data;
                  main_src_reg  <= sel_src;
                  state_reg     <= BUSY;
                  out_valid_reg <= 1'b1;
               end
            end
            BUSY: begin
               if (in_hs && out_hs) begin
                  main_data_reg <= sel_data;
                  main_src_reg  <= sel_src;
               end else if (in_hs) begin
                  // Downstream stalled: park the newcomer behind main
                  skid_data_reg <= sel_data;
                  skid_src_reg  <= sel_src;
                  state_reg     <= FULL;
                  in_ready_reg  <= 1'b0;
               end else if (out_hs) begin
                  state_reg     <= EMPTY;
                  out_valid_reg <= 1'b0;
               end
            end
            FULL: begin
               if (out_hs) begin
                  main_data_reg <= skid_data_reg;
                  main_src_reg  <= skid_src_reg;
                  state_reg     <= BUSY;
                  in_ready_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg     <= EMPTY;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

`ifdef FWD_MUX_PIPE_STATS_EN
   logic [FWD_CNT_W-1:0] fwd_count_reg;

   // Flush suppresses counting of a same-cycle handshake but never clears
   // the running total.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fwd_count_reg <= '0;
      end else if (!bus.flush && in_hs && (sel_src != '0)) begin
         fwd_count_reg <= fwd_sat_inc(fwd_count_reg);
      end
   end

   assign fwd_count = fwd_count_reg;
`else
   // Statistics disabled: no counter, no port.
`endif

endmodule
